// File: rtl/lcd_nibble_transfer_pkg.sv
// Shared LCD definitions: write-engine state encoding, bus word layout and
// HD44780 execution delays expressed in 50 MHz clock cycles.
package lcd_nibble_transfer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_PULSE   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DELAY   = 3'd4,
    ST_DONE    = 3'd5,
    ST_RELEASE = 3'd6
  } lcd_state_e;

  localparam int unsigned LCD_RS_BIT  = 4;
  localparam int unsigned LCD_WORD_W  = LCD_RS_BIT + 1;
  localparam int unsigned LCD_CLK_MHZ = 50;

  function automatic int unsigned lcd_us_to_cycles(input int unsigned us);
    return us * LCD_CLK_MHZ;
  endfunction

  // Post-strobe waits the init/text sequencer feeds into commandDelay.
  localparam int unsigned LCD_DLY_1US   = lcd_us_to_cycles(1);
  localparam int unsigned LCD_DLY_10US  = lcd_us_to_cycles(10);
  localparam int unsigned LCD_DLY_53US  = lcd_us_to_cycles(53);
  localparam int unsigned LCD_DLY_100US = lcd_us_to_cycles(100);
  localparam int unsigned LCD_DLY_3MS   = lcd_us_to_cycles(3000);
  localparam int unsigned LCD_DLY_4P1MS = lcd_us_to_cycles(4100);

endpackage

// File: rtl/lcd_nibble_transfer.sv
// HD44780 4-bit write engine: drives one {RS, nibble} word, strobes LCD_E,
// waits the requested execution delay and pulses commandDone once.
module lcd_nibble_transfer
  import lcd_nibble_transfer_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned PULSE_CYCLES = 12,
  parameter int unsigned HOLD_CYCLES  = 1,
  parameter int unsigned DELAY_W      = 21
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  sendCommand,
  input  logic [LCD_WORD_W-1:0] command,
  input  logic [DELAY_W-1:0]    commandDelay,
  output logic                  commandDone,
  output logic [LCD_WORD_W-1:0] LCD_D,
  output logic                  LCD_E
);

  localparam int unsigned PHASE_MAX =
    (SETUP_CYCLES > PULSE_CYCLES) ?
      ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
      ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
  localparam int unsigned PHASE_W = $clog2(PHASE_MAX + 1);

  localparam logic [PHASE_W-1:0] SETUP_LOAD = PHASE_W'(SETUP_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PULSE_LOAD = PHASE_W'(PULSE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HOLD_LOAD  = PHASE_W'(HOLD_CYCLES - 1);

  lcd_state_e            state_q, state_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [DELAY_W-1:0]    delay_q, delay_d;
  logic [LCD_WORD_W-1:0] lcd_d_q, lcd_d_d;
  logic                  lcd_e_q, lcd_e_d;
  logic                  done_q,  done_d;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d = state_q;
    phase_d = phase_q;
    delay_d = delay_q;
    lcd_d_d = lcd_d_q;
    lcd_e_d = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sendCommand) begin
          lcd_d_d = command;
          delay_d = commandDelay;
          phase_d = SETUP_LOAD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (phase_q == '0) begin
          phase_d = PULSE_LOAD;
          lcd_e_d = 1'b1;
          state_d = ST_PULSE;
        end else begin
          phase_d = phase_q - PHASE_W'(1);
        end
      end
      ST_PULSE: begin
        if (phase_q == '0) begin
          phase_d = HOLD_LOAD;
          state_d = ST_HOLD;
        end else begin
          phase_d = phase_q - PHASE_W'(1);
          lcd_e_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (phase_q != '0) begin
          phase_d = phase_q - PHASE_W'(1);
        end else if (delay_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_DELAY;
        end
      end
      ST_DELAY: begin
        // Entered with a non-zero count; the last counted cycle raises done.
        delay_d = delay_q - DELAY_W'(1);
        if (delay_q == DELAY_W'(1)) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!sendCommand) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      delay_q <= '0;
      lcd_d_q <= '0;
      lcd_e_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      phase_q <= phase_d;
      delay_q <= delay_d;
      lcd_d_q <= lcd_d_d;
      lcd_e_q <= lcd_e_d;
      done_q  <= done_d;
    end
  end

  assign LCD_D       = lcd_d_q;
  assign LCD_E       = lcd_e_q;
  assign commandDone = done_q;

endmodule

// File: tb/tb_lcd_nibble_transfer.sv
// Self-checking bench for lcd_nibble_transfer: expected strobe/done timing is
// computed per transfer from the setup/pulse/hold/delay cycle arithmetic.
module tb_lcd_nibble_transfer;
  import lcd_nibble_transfer_pkg::*;

  localparam int S  = 2;
  localparam int P  = 12;
  localparam int H  = 1;
  localparam int DW = 21;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          sendCommand;
  logic [4:0]    command;
  logic [DW-1:0] commandDelay;
  logic          commandDone;
  logic [4:0]    LCD_D;
  logic          LCD_E;

  int tests = 0;
  int fails = 0;

  lcd_nibble_transfer #(
    .SETUP_CYCLES(S),
    .PULSE_CYCLES(P),
    .HOLD_CYCLES (H),
    .DELAY_W     (DW)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .sendCommand (sendCommand),
    .command     (command),
    .commandDelay(commandDelay),
    .commandDone (commandDone),
    .LCD_D       (LCD_D),
    .LCD_E       (LCD_E)
  );

  always #5 CLK = ~CLK;

  // Runs one transfer from a known-idle DUT. Edge 0 is the first rising edge
  // after the request is raised. Inputs are scrambled after capture; the
  // request drops after edge drop_k (never if drop_k < 0).
  task automatic run_transfer(input string name, input logic [4:0] cmd,
                              input int dly, input int drop_k);
    int total;
    logic exp_e, exp_done;
    total = S + P + H + dly;
    @(posedge CLK); #1;
    sendCommand  = 1'b1;
    command      = cmd;
    commandDelay = DW'(dly);
    for (int k = 0; k <= total + 1; k++) begin
      @(posedge CLK); #1;
      command      = 5'($urandom);
      commandDelay = DW'($urandom_range(0, 7));
      exp_e    = (k >= S) && (k < S + P);
      exp_done = (k == total);
      tests++;
      if (LCD_D !== cmd) begin
        fails++;
        $display("FAIL %s lcd_d edge %0d: got %h want %h", name, k, LCD_D, cmd);
      end
      tests++;
      if (LCD_E !== exp_e) begin
        fails++;
        $display("FAIL %s lcd_e edge %0d: got %b want %b", name, k, LCD_E, exp_e);
      end
      tests++;
      if (commandDone !== exp_done) begin
        fails++;
        $display("FAIL %s done edge %0d: got %b want %b", name, k, commandDone, exp_done);
      end
      if (k == drop_k) sendCommand = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST_N        = 1'b0;
    sendCommand  = 1'b1;
    command      = 5'h1F;
    commandDelay = DW'(3);
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      tests++;
      if ({LCD_D, LCD_E, commandDone} !== 7'd0) begin
        fails++;
        $display("FAIL reset cycle %0d: got d=%h e=%b done=%b want all 0",
                 i, LCD_D, LCD_E, commandDone);
      end
    end
    sendCommand = 1'b0;
    RST_N       = 1'b1;
  endtask

  task automatic test_basic_write();
    run_transfer("basic", 5'b10011, 5, S + P + H + 5 + 1);
  endtask

  task automatic test_zero_delay();
    run_transfer("zero_delay", 5'b00010, 0, S + P + H + 1);
  endtask

  task automatic test_held_request();
    run_transfer("held", 5'b11010, 3, -1);
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      tests++;
      if (LCD_E !== 1'b0 || commandDone !== 1'b0) begin
        fails++;
        $display("FAIL held retrigger cycle %0d: got e=%b done=%b want 0 0",
                 i, LCD_E, commandDone);
      end
    end
    sendCommand = 1'b0;
    @(posedge CLK); #1;
    run_transfer("held_rearm", 5'b00101, 2, S + P + H + 2 + 1);
  endtask

  task automatic test_back_to_back();
    run_transfer("b2b_first", 5'b10110, 4, S + P + H + 4);
    run_transfer("b2b_second", 5'b01100, 1, S + P + H + 1 + 1);
  endtask

  task automatic test_abort_drop();
    run_transfer("abort_drop", 5'b11111, 6, S + 3);
  endtask

  task automatic test_abort_reset();
    @(posedge CLK); #1;
    sendCommand  = 1'b1;
    command      = 5'b10101;
    commandDelay = DW'(LCD_DLY_3MS);
    for (int k = 0; k < S + P + H + 20; k++) begin
      @(posedge CLK); #1;
    end
    tests++;
    if (LCD_D !== 5'b10101 || LCD_E !== 1'b0 || commandDone !== 1'b0) begin
      fails++;
      $display("FAIL abort_reset pre: got d=%h e=%b done=%b want 15 0 0",
               LCD_D, LCD_E, commandDone);
    end
    #2 RST_N = 1'b0;
    #1;
    tests++;
    if ({LCD_D, LCD_E, commandDone} !== 7'd0) begin
      fails++;
      $display("FAIL abort_reset immediate: got d=%h e=%b done=%b want all 0",
               LCD_D, LCD_E, commandDone);
    end
    sendCommand = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      tests++;
      if (commandDone !== 1'b0 || LCD_E !== 1'b0) begin
        fails++;
        $display("FAIL abort_reset quiet cycle %0d: got done=%b e=%b want 0 0",
                 i, commandDone, LCD_E);
      end
    end
    run_transfer("after_reset", 5'b01001, 2, S + P + H + 2 + 1);
  endtask

  task automatic test_random();
    logic [4:0] cmd;
    int dly, total, drop;
    for (int n = 0; n < 8; n++) begin
      cmd   = 5'($urandom);
      dly   = $urandom_range(0, 40);
      total = S + P + H + dly;
      case ($urandom_range(0, 2))
        0:       drop = total + 1;
        1:       drop = total;
        default: drop = $urandom_range(0, total);
      endcase
      run_transfer($sformatf("random%0d", n), cmd, dly, drop);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_zero_delay();
    test_held_request();
    test_back_to_back();
    test_abort_drop();
    test_abort_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_transfer.md
# lcd_nibble_transfer

Low-level HD44780 4-bit-mode write engine (instantiated as `lcd_transfer`). It places one RS+nibble word on the LCD bus, generates a timed enable strobe, then waits a caller-specified execution delay before reporting completion. It sits beneath the LCD init/text sequencer, which issues one nibble per handshake.

## Interface
Parameters:
- `SETUP_CYCLES`, 2: cycles `LCD_D` is stable before `LCD_E` rises (≥40 ns at 50 MHz).
- `PULSE_CYCLES`, 12: `LCD_E` high width (≥230 ns at 50 MHz).
- `HOLD_CYCLES`, 1: cycles after `LCD_E` falls before the delay phase starts.
- `DELAY_W`, 21: width of `commandDelay`.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `sendCommand` in 1: level request; held high by the caller until it sees `commandDone`.
- `command` in 5: bit 4 = RS, bits 3:0 = D7..D4 nibble.
- `commandDelay` in `DELAY_W`: post-strobe wait in clock cycles.
- `commandDone` out 1: one-cycle completion pulse.
- `LCD_D` out 5: {RS, D7..D4} to the panel.
- `LCD_E` out 1: enable strobe.

## Operation
- All outputs are registered. Reset values: `LCD_D`=0, `LCD_E`=0, `commandDone`=0, state IDLE, counters 0.
- State machine: IDLE → SETUP → PULSE → HOLD → DELAY → DONE → RELEASE → IDLE.
- IDLE: on `sendCommand`=1, latch `command` into `LCD_D` and `commandDelay` into the delay counter; go to SETUP.
- SETUP: `LCD_E`=0 for `SETUP_CYCLES`, then PULSE.
- PULSE: `LCD_E`=1 for `PULSE_CYCLES`, then HOLD.
- HOLD: `LCD_E`=0 for `HOLD_CYCLES`. Then DELAY, or DONE directly if the latched delay is 0.
- DELAY: count exactly the latched delay, then DONE.
- DONE: `commandDone`=1 for exactly one cycle, then RELEASE.
- RELEASE: wait for `sendCommand`=0, then IDLE. This prevents a still-high request from retriggering a second transfer.
- `LCD_D` holds the last command until the next capture; it is not cleared after a transfer.
- `command` and `commandDelay` are sampled only at capture. Input changes mid-transfer are ignored.
- If `sendCommand` drops mid-transfer, the transfer still completes and `commandDone` still pulses. RELEASE then falls straight through to IDLE.
- The delay counter is `DELAY_W` bits wide and counts down. The maximum value is 2^21−1 cycles. There is no wrap.
- Reset asserted mid-transfer: all outputs return to reset values immediately and the state returns to IDLE. No `commandDone` is produced.

## Timing
- Edge 0 is the edge at which IDLE samples `sendCommand`=1.
- `LCD_D` is valid after edge 0.
- `LCD_E` goes high after edge `SETUP_CYCLES` and low after edge `SETUP_CYCLES+PULSE_CYCLES`.
- `commandDone` is high after edge S+P+H+D for one cycle (defaults: 15+D).
- Caller handshake: the caller clears its request in the cycle after `commandDone`, and may re-raise it one cycle later.
- The earliest next capture is 2 cycles after the `commandDone` cycle.

## Structure
- Shared LCD package holds:
  - the state enum;
  - the RS bit index (4);
  - timing constants derived from the 50 MHz clock (1 µs = 50 cycles; 10 µs, 53 µs, 100 µs, 3 ms, 4.1 ms). The sequencer uses these constants for its `commandDelay` values.
- Single flat module with one FSM, one phase counter (setup/pulse/hold) and one `DELAY_W` delay counter. No sub-modules.

## Test plan
- Reset: hold `RST_N`=0 with `sendCommand`=1 → `LCD_D`=0, `LCD_E`=0, `commandDone`=0 throughout.
- Basic write: `command`=5'b10011, `commandDelay`=5. Required response:
  - `LCD_D`=5'h13 after edge 0;
  - `LCD_E`=1 after edges 2..13 only;
  - `commandDone`=1 after edge 20 only.
- Zero delay: `command`=5'b00010, `commandDelay`=0 → `commandDone` pulses after edge 15 for exactly one cycle.
- Held request: keep `sendCommand`=1 for 10 cycles after `commandDone` → no second `LCD_E` pulse. Drop it, then raise it again → a new transfer starts.
- Back-to-back: caller drops the request on the `commandDone` cycle and re-raises it two cycles later with 5'b01100 → the second capture occurs, `LCD_D`=5'h0C, and there is exactly one `commandDone` per request.
- Abort paths, two cases:
  - drop `sendCommand` during PULSE → the transfer still completes with one `commandDone`;
  - assert `RST_N`=0 during DELAY (`commandDelay`=150000) → outputs reset immediately and no `commandDone` appears.
